// File: rtl/mcycle_ctrl_pkg.sv
// Shared definitions for the multicycle MIPS control path: state encoding,
// opcode constants, datapath mux encodings and the control-word bundle.
package mcycle_ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC   = 4'd6,
    S_ALUWB  = 4'd7,
    S_BRANCH = 4'd8,
    S_ADDIEX = 4'd9,
    S_ADDIWB = 4'd10,
    S_JUMP   = 4'd11
  } state_e;

  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] SRCB_RT    = 2'b00;
  localparam logic [1:0] SRCB_FOUR  = 2'b01;
  localparam logic [1:0] SRCB_IMM   = 2'b10;
  localparam logic [1:0] SRCB_IMMSH = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  // Datapath control word produced by the output decoder
  typedef struct packed {
    logic       mem_req;
    logic       iord;
    logic       memwrite;
    logic       irwrite;
    logic       regdst;
    logic       memtoreg;
    logic       regwrite;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic [1:0] aluop;
    logic [1:0] pcsrc;
    logic       pcen;
  } ctrl_t;

  function automatic logic op_supported(input logic [5:0] op);
    return (op == OP_LW) || (op == OP_SW) || (op == OP_RTYPE) ||
           (op == OP_BEQ) || (op == OP_ADDI) || (op == OP_J);
  endfunction

endpackage

// File: rtl/mcycle_ctrl_outdec.sv
// Moore output decoder: maps the current state (plus zero / mem_ready
// qualifiers) to the datapath control word.
module mcycle_outdec
  import mcycle_ctrl_pkg::*;
(
  input  state_e state,
  input  logic   zero,
  input  logic   mem_ready,
  output ctrl_t  ctrl_o
);

  // Per-state control word; everything not listed stays 0
  always_comb begin
    ctrl_o = '0;
    unique case (state)
      S_FETCH: begin
        ctrl_o.mem_req = 1'b1;
        ctrl_o.alusrcb = SRCB_FOUR;
        ctrl_o.aluop   = ALUOP_ADD;
        ctrl_o.pcsrc   = PCSRC_ALU;
        ctrl_o.irwrite = mem_ready;
        ctrl_o.pcen    = mem_ready;
      end
      S_DECODE: begin
        ctrl_o.alusrcb = SRCB_IMMSH;
        ctrl_o.aluop   = ALUOP_ADD;
      end
      S_MEMADR, S_ADDIEX: begin
        ctrl_o.alusrca = 1'b1;
        ctrl_o.alusrcb = SRCB_IMM;
        ctrl_o.aluop   = ALUOP_ADD;
      end
      S_MEMRD: begin
        ctrl_o.mem_req = 1'b1;
        ctrl_o.iord    = 1'b1;
      end
      S_MEMWR: begin
        ctrl_o.mem_req  = 1'b1;
        ctrl_o.iord     = 1'b1;
        ctrl_o.memwrite = 1'b1;
      end
      S_MEMWB: begin
        ctrl_o.regwrite = 1'b1;
        ctrl_o.memtoreg = 1'b1;
      end
      S_EXEC: begin
        ctrl_o.alusrca = 1'b1;
        ctrl_o.alusrcb = SRCB_RT;
        ctrl_o.aluop   = ALUOP_FUNCT;
      end
      S_ALUWB: begin
        ctrl_o.regwrite = 1'b1;
        ctrl_o.regdst   = 1'b1;
      end
      S_ADDIWB: begin
        ctrl_o.regwrite = 1'b1;
      end
      S_BRANCH: begin
        ctrl_o.alusrca = 1'b1;
        ctrl_o.alusrcb = SRCB_RT;
        ctrl_o.aluop   = ALUOP_SUB;
        ctrl_o.pcsrc   = PCSRC_ALUOUT;
        ctrl_o.pcen    = zero;
      end
      S_JUMP: begin
        ctrl_o.pcsrc = PCSRC_JUMP;
        ctrl_o.pcen  = 1'b1;
      end
      default: ctrl_o = '0;
    endcase
  end

endmodule

// File: rtl/mcycle_ctrl.sv
// Multicycle MIPS main controller: state register, next-state logic and
// reset gating of the strobe outputs. Output decoding lives in mcycle_outdec.
module mcycle_ctrl
  import mcycle_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] op,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       iord,
  output logic       memwrite,
  output logic       irwrite,
  output logic       regdst,
  output logic       memtoreg,
  output logic       regwrite,
  output logic       alusrca,
  output logic [1:0] alusrcb,
  output logic [1:0] aluop,
  output logic [1:0] pcsrc,
  output logic       pcen,
  output logic       illegal
);

  state_e state_q, state_d;
  ctrl_t  ctrl;

  // Next-state selection
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_FETCH:  state_d = mem_ready ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (op)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_RTYPE:     state_d = S_EXEC;
          OP_BEQ:       state_d = S_BRANCH;
          OP_ADDI:      state_d = S_ADDIEX;
          OP_J:         state_d = S_JUMP;
          default:      state_d = S_FETCH;
        endcase
      end
      S_MEMADR: state_d = (op == OP_SW) ? S_MEMWR : S_MEMRD;
      S_MEMRD:  state_d = mem_ready ? S_MEMWB : S_MEMRD;
      S_MEMWR:  state_d = mem_ready ? S_FETCH : S_MEMWR;
      S_EXEC:   state_d = S_ALUWB;
      S_ADDIEX: state_d = S_ADDIWB;
      S_MEMWB, S_ALUWB, S_ADDIWB, S_BRANCH, S_JUMP: state_d = S_FETCH;
      default:  state_d = S_FETCH;
    endcase
  end

  // State register; reset wins over any pending transition or memory wait
  always_ff @(posedge clk) begin
    if (reset) state_q <= S_FETCH;
    else       state_q <= state_d;
  end

  mcycle_outdec u_outdec (
    .state     (state_q),
    .zero      (zero),
    .mem_ready (mem_ready),
    .ctrl_o    (ctrl)
  );

  // Strobes are suppressed while reset is held; mux selects pass through
  always_comb begin
    mem_req  = ctrl.mem_req  & ~reset;
    iord     = ctrl.iord;
    memwrite = ctrl.memwrite & ~reset;
    irwrite  = ctrl.irwrite  & ~reset;
    regdst   = ctrl.regdst;
    memtoreg = ctrl.memtoreg;
    regwrite = ctrl.regwrite & ~reset;
    alusrca  = ctrl.alusrca;
    alusrcb  = ctrl.alusrcb;
    aluop    = ctrl.aluop;
    pcsrc    = ctrl.pcsrc;
    pcen     = ctrl.pcen     & ~reset;
    illegal  = (state_q == S_DECODE) & ~op_supported(op) & ~reset;
  end

endmodule

// File: tb/tb_mcycle_ctrl.sv
// Directed bench for mcycle_ctrl: walks each instruction class cycle by
// cycle and compares the full output vector against hand-written values.
module tb_mcycle_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] op;
  logic       zero;
  logic       mem_ready;
  logic       mem_req, iord, memwrite, irwrite, regdst, memtoreg, regwrite;
  logic       alusrca, pcen, illegal;
  logic [1:0] alusrcb, aluop, pcsrc;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  always #5 clk = ~clk;

  mcycle_ctrl dut (
    .clk       (clk),
    .reset     (reset),
    .op        (op),
    .zero      (zero),
    .mem_ready (mem_ready),
    .mem_req   (mem_req),
    .iord      (iord),
    .memwrite  (memwrite),
    .irwrite   (irwrite),
    .regdst    (regdst),
    .memtoreg  (memtoreg),
    .regwrite  (regwrite),
    .alusrca   (alusrca),
    .alusrcb   (alusrcb),
    .aluop     (aluop),
    .pcsrc     (pcsrc),
    .pcen      (pcen),
    .illegal   (illegal)
  );

  // Observed vector: {mem_req,iord,memwrite,irwrite,regdst,memtoreg,
  //                   regwrite,alusrca,alusrcb,aluop,pcsrc,pcen,illegal}
  logic [15:0] obs;
  assign obs = {mem_req, iord, memwrite, irwrite, regdst, memtoreg, regwrite,
                alusrca, alusrcb, aluop, pcsrc, pcen, illegal};

  function automatic logic [15:0] ov(
    input logic mreq, input logic io, input logic mw, input logic irw,
    input logic rdst, input logic m2r, input logic rw, input logic asa,
    input logic [1:0] asb, input logic [1:0] aop, input logic [1:0] psrc,
    input logic pce, input logic ill);
    return {mreq, io, mw, irw, rdst, m2r, rw, asa, asb, aop, psrc, pce, ill};
  endfunction

  // Expected per-state vectors
  logic [15:0] E_FETCH_W, E_FETCH_R, E_DECODE, E_DECODE_ILL, E_MEMADR, E_MEMRD,
               E_MEMWR, E_MEMWB, E_EXEC, E_ALUWB, E_ADDIWB, E_BR_T, E_BR_N,
               E_JUMP, E_RST_MEMRD;

  task automatic check_eq(input string tag, input logic [15:0] got,
                          input logic [15:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%b exp=%b", tag, got, exp);
    end
  endtask

  // One clock cycle: drive inputs mid-low-phase, check, then let the edge pass
  task automatic cyc(input string tag, input logic [5:0] o, input logic z,
                     input logic mr, input logic rst, input logic [15:0] exp);
    @(negedge clk);
    op = o; zero = z; mem_ready = mr; reset = rst;
    #1;
    check_eq(tag, obs, exp);
    @(posedge clk);
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    E_FETCH_W    = ov(1,0,0,0,0,0,0,0,2'b01,2'b00,2'b00,0,0);
    E_FETCH_R    = ov(1,0,0,1,0,0,0,0,2'b01,2'b00,2'b00,1,0);
    E_DECODE     = ov(0,0,0,0,0,0,0,0,2'b11,2'b00,2'b00,0,0);
    E_DECODE_ILL = ov(0,0,0,0,0,0,0,0,2'b11,2'b00,2'b00,0,1);
    E_MEMADR     = ov(0,0,0,0,0,0,0,1,2'b10,2'b00,2'b00,0,0);
    E_MEMRD      = ov(1,1,0,0,0,0,0,0,2'b00,2'b00,2'b00,0,0);
    E_MEMWR      = ov(1,1,1,0,0,0,0,0,2'b00,2'b00,2'b00,0,0);
    E_MEMWB      = ov(0,0,0,0,0,1,1,0,2'b00,2'b00,2'b00,0,0);
    E_EXEC       = ov(0,0,0,0,0,0,0,1,2'b00,2'b10,2'b00,0,0);
    E_ALUWB      = ov(0,0,0,0,1,0,1,0,2'b00,2'b00,2'b00,0,0);
    E_ADDIWB     = ov(0,0,0,0,0,0,1,0,2'b00,2'b00,2'b00,0,0);
    E_BR_T       = ov(0,0,0,0,0,0,0,1,2'b00,2'b01,2'b01,1,0);
    E_BR_N       = ov(0,0,0,0,0,0,0,1,2'b00,2'b01,2'b01,0,0);
    E_JUMP       = ov(0,0,0,0,0,0,0,0,2'b00,2'b00,2'b10,1,0);
    E_RST_MEMRD  = ov(0,1,0,0,0,0,0,0,2'b00,2'b00,2'b00,0,0);

    reset = 1'b1; op = 6'b000000; zero = 1'b0; mem_ready = 1'b1;
    repeat (2) @(posedge clk);
    // Held in reset: state is FETCH but strobes are forced low
    cyc("reset_hold", 6'b100011, 1'b0, 1'b1, 1'b1,
        ov(0,0,0,0,0,0,0,0,2'b01,2'b00,2'b00,0,0));

    // First cycle out of reset is FETCH; two wait cycles then lw
    cyc("fetch_wait0", 6'b100011, 0, 0, 0, E_FETCH_W);
    cyc("fetch_wait1", 6'b100011, 0, 0, 0, E_FETCH_W);
    cyc("lw_fetch",    6'b100011, 0, 1, 0, E_FETCH_R);
    cyc("lw_decode",   6'b100011, 0, 1, 0, E_DECODE);
    cyc("lw_memadr",   6'b100011, 0, 1, 0, E_MEMADR);
    cyc("lw_memrd",    6'b100011, 0, 1, 0, E_MEMRD);
    cyc("lw_memwb",    6'b100011, 0, 1, 0, E_MEMWB);

    // sw with three memory wait cycles in MEMWR
    cyc("sw_fetch",    6'b101011, 0, 1, 0, E_FETCH_R);
    cyc("sw_decode",   6'b101011, 0, 1, 0, E_DECODE);
    cyc("sw_memadr",   6'b101011, 0, 1, 0, E_MEMADR);
    cyc("sw_memwr0",   6'b101011, 0, 0, 0, E_MEMWR);
    cyc("sw_memwr1",   6'b101011, 0, 0, 0, E_MEMWR);
    cyc("sw_memwr2",   6'b101011, 0, 0, 0, E_MEMWR);
    cyc("sw_memwr3",   6'b101011, 0, 1, 0, E_MEMWR);

    // beq taken
    cyc("beqt_fetch",  6'b000100, 1, 1, 0, E_FETCH_R);
    cyc("beqt_decode", 6'b000100, 1, 1, 0, E_DECODE);
    cyc("beqt_branch", 6'b000100, 1, 1, 0, E_BR_T);
    // beq not taken
    cyc("beqn_fetch",  6'b000100, 0, 1, 0, E_FETCH_R);
    cyc("beqn_decode", 6'b000100, 0, 1, 0, E_DECODE);
    cyc("beqn_branch", 6'b000100, 0, 1, 0, E_BR_N);

    // R-type
    cyc("r_fetch",     6'b000000, 0, 1, 0, E_FETCH_R);
    cyc("r_decode",    6'b000000, 0, 1, 0, E_DECODE);
    cyc("r_exec",      6'b000000, 0, 1, 0, E_EXEC);
    cyc("r_aluwb",     6'b000000, 0, 1, 0, E_ALUWB);

    // addi
    cyc("addi_fetch",  6'b001000, 0, 1, 0, E_FETCH_R);
    cyc("addi_decode", 6'b001000, 0, 1, 0, E_DECODE);
    cyc("addi_ex",     6'b001000, 0, 1, 0, E_MEMADR);
    cyc("addi_wb",     6'b001000, 0, 1, 0, E_ADDIWB);

    // j
    cyc("j_fetch",     6'b000010, 0, 1, 0, E_FETCH_R);
    cyc("j_decode",    6'b000010, 0, 1, 0, E_DECODE);
    cyc("j_jump",      6'b000010, 0, 1, 0, E_JUMP);

    // Illegal opcode: pulse in DECODE, straight back to FETCH
    cyc("ill_fetch",   6'b111111, 0, 1, 0, E_FETCH_R);
    cyc("ill_decode",  6'b111111, 0, 1, 0, E_DECODE_ILL);
    cyc("ill_refetch", 6'b111111, 0, 0, 0, E_FETCH_W);

    // Reset in the middle of a lw memory wait
    cyc("rst_fetch",   6'b100011, 0, 1, 0, E_FETCH_R);
    cyc("rst_decode",  6'b100011, 0, 1, 0, E_DECODE);
    cyc("rst_memadr",  6'b100011, 0, 1, 0, E_MEMADR);
    cyc("rst_memrd",   6'b100011, 0, 0, 0, E_MEMRD);
    cyc("rst_assert",  6'b100011, 0, 0, 1, E_RST_MEMRD);
    cyc("rst_refetch", 6'b100011, 0, 0, 0, E_FETCH_W);
    cyc("rst_fetch2",  6'b100011, 0, 1, 0, E_FETCH_R);
    cyc("rst_decode2", 6'b100011, 0, 1, 0, E_DECODE);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
